// File: rtl/rv32i_types_pkg.sv
// Shared types for the dispatch scoreboard: completion-buffer index and
// per-register tracking entry.
package rv32i_types_pkg;

  localparam int CB_DEPTH = 16;
  localparam int CB_TW    = $clog2(CB_DEPTH);
  localparam int REG_AW   = 5;

  typedef logic [CB_TW-1:0] cb_index_t;

  typedef struct packed {
    logic      busy;
    logic      done;
    cb_index_t tag;
  } sb_entry_t;

endpackage

// File: rtl/dispatch_scoreboard_if.sv
// Dispatch / write-back / commit bundle between the decode stage, the
// completion buffer and the scoreboard.
interface dispatch_scoreboard_if #(parameter int TW = 4);

  logic          dispatch_valid;
  logic [4:0]    dispatch_rd;
  logic [4:0]    dispatch_rs1;
  logic [4:0]    dispatch_rs2;
  logic          dispatch_wen;
  logic          cb_full;
  logic [TW-1:0] cb_tail;
  logic          wb_valid_a, wb_valid_mu, wb_valid_du, wb_valid_ls;
  logic [TW-1:0] wb_index_a, wb_index_mu, wb_index_du, wb_index_ls;
  logic          commit_valid;
  logic [4:0]    commit_rd;
  logic [TW-1:0] commit_index;
  logic          flush;
  logic          alloc_ena;
  logic          stall;
  logic          rs1_fwd, rs2_fwd;
  logic [TW-1:0] rs1_tag, rs2_tag;
  logic [TW:0]   inflight_cnt;

  modport master (
    output dispatch_valid, dispatch_rd, dispatch_rs1, dispatch_rs2, dispatch_wen,
    output cb_full, cb_tail,
    output wb_valid_a, wb_valid_mu, wb_valid_du, wb_valid_ls,
    output wb_index_a, wb_index_mu, wb_index_du, wb_index_ls,
    output commit_valid, commit_rd, commit_index, flush,
    input  alloc_ena, stall, rs1_fwd, rs2_fwd, rs1_tag, rs2_tag, inflight_cnt
  );

  modport slave (
    input  dispatch_valid, dispatch_rd, dispatch_rs1, dispatch_rs2, dispatch_wen,
    input  cb_full, cb_tail,
    input  wb_valid_a, wb_valid_mu, wb_valid_du, wb_valid_ls,
    input  wb_index_a, wb_index_mu, wb_index_du, wb_index_ls,
    input  commit_valid, commit_rd, commit_index, flush,
    output alloc_ena, stall, rs1_fwd, rs2_fwd, rs1_tag, rs2_tag, inflight_cnt
  );

endinterface

// File: rtl/dispatch_scoreboard.sv
// Register scoreboard: tracks which architectural registers wait on an
// in-flight completion-buffer entry and whether operands can be forwarded.
module dispatch_scoreboard
  import rv32i_types_pkg::*;
#(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_REG   = 32
) (
  input logic                 CLK,
  input logic                 RST,
  dispatch_scoreboard_if.slave sb
);

  localparam int TW = $clog2(NUM_ENTRY);
  localparam int CW = TW + 1;

  sb_entry_t      sb_q [NUM_REG];
  sb_entry_t      sb_d [NUM_REG];
  logic [CW-1:0]  cnt_q, cnt_d;

  sb_entry_t      e1, e2;
  logic           pend1, pend2, do_alloc;

  // x0 and out-of-range indices read as an idle entry
  function automatic sb_entry_t lookup(input logic [4:0] idx);
    sb_entry_t e;
    e = '0;
    if (idx != 5'd0 && 32'(idx) < NUM_REG) e = sb_q[idx];
    return e;
  endfunction

  always_comb begin
    e1    = lookup(sb.dispatch_rs1);
    e2    = lookup(sb.dispatch_rs2);
    pend1 = e1.busy & ~e1.done;
    pend2 = e2.busy & ~e2.done;
  end

  assign sb.stall     = sb.dispatch_valid & (sb.cb_full | pend1 | pend2);
  assign sb.alloc_ena = sb.dispatch_valid & ~sb.stall & ~sb.flush;
  assign sb.rs1_fwd   = e1.busy & e1.done;
  assign sb.rs2_fwd   = e2.busy & e2.done;
  assign sb.rs1_tag   = sb.rs1_fwd ? e1.tag : '0;
  assign sb.rs2_tag   = sb.rs2_fwd ? e2.tag : '0;
  assign sb.inflight_cnt = cnt_q;

  assign do_alloc = sb.alloc_ena & sb.dispatch_wen & (sb.dispatch_rd != 5'd0);

  // Update order wb -> commit -> dispatch so the newest allocation wins
  always_comb begin
    for (int i = 0; i < NUM_REG; i++) sb_d[i] = sb_q[i];
    if (sb.flush) begin
      for (int i = 0; i < NUM_REG; i++) begin
        sb_d[i].busy = 1'b0;
        sb_d[i].done = 1'b0;
      end
    end else begin
      for (int i = 1; i < NUM_REG; i++) begin
        if (sb_q[i].busy &&
            ((sb.wb_valid_a  && sb.wb_index_a  == sb_q[i].tag) ||
             (sb.wb_valid_mu && sb.wb_index_mu == sb_q[i].tag) ||
             (sb.wb_valid_du && sb.wb_index_du == sb_q[i].tag) ||
             (sb.wb_valid_ls && sb.wb_index_ls == sb_q[i].tag)))
          sb_d[i].done = 1'b1;
      end
      if (sb.commit_valid && sb.commit_rd != 5'd0 && 32'(sb.commit_rd) < NUM_REG &&
          sb_q[sb.commit_rd].tag == sb.commit_index) begin
        sb_d[sb.commit_rd].busy = 1'b0;
        sb_d[sb.commit_rd].done = 1'b0;
      end
      if (do_alloc && 32'(sb.dispatch_rd) < NUM_REG) begin
        sb_d[sb.dispatch_rd].busy = 1'b1;
        sb_d[sb.dispatch_rd].done = 1'b0;
        sb_d[sb.dispatch_rd].tag  = cb_index_t'(sb.cb_tail);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sb.flush)
      cnt_d = '0;
    else if (do_alloc && !sb.commit_valid)
      cnt_d = (cnt_q == CW'(NUM_ENTRY)) ? cnt_q : cnt_q + CW'(1);
    else if (sb.commit_valid && !do_alloc)
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REG; i++) sb_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) sb_q[i] <= sb_d[i];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Directed bench for dispatch_scoreboard: hazards, forwarding, WAW, flush,
// x0, counter saturation and asynchronous reset.
module tb_dispatch_scoreboard;

  logic CLK = 1'b0;
  logic RST;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  dispatch_scoreboard_if #(.TW(4)) bus ();

  dispatch_scoreboard #(.NUM_ENTRY(16), .NUM_REG(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .sb  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.dispatch_valid = 0; bus.dispatch_rd = 0; bus.dispatch_rs1 = 0;
    bus.dispatch_rs2 = 0;   bus.dispatch_wen = 0; bus.cb_full = 0; bus.cb_tail = 0;
    bus.wb_valid_a = 0; bus.wb_valid_mu = 0; bus.wb_valid_du = 0; bus.wb_valid_ls = 0;
    bus.wb_index_a = 0; bus.wb_index_mu = 0; bus.wb_index_du = 0; bus.wb_index_ls = 0;
    bus.commit_valid = 0; bus.commit_rd = 0; bus.commit_index = 0; bus.flush = 0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic wen, input logic [3:0] tail);
    bus.dispatch_valid = 1; bus.dispatch_rd = rd; bus.dispatch_rs1 = rs1;
    bus.dispatch_rs2 = rs2; bus.dispatch_wen = wen; bus.cb_tail = tail;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] idx);
    bus.commit_valid = 1; bus.commit_rd = rd; bus.commit_index = idx;
  endtask

  initial begin
    idle();
    RST = 1;
    disp(0, 5, 5, 1, 0); bus.cb_full = 1; #1;
    chk("rst_stall_full", bus.stall, 1);
    chk("rst_alloc_full", bus.alloc_ena, 0);
    bus.cb_full = 0; #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_alloc", bus.alloc_ena, 1);
    bus.flush = 1; #1;
    chk("rst_alloc_flush", bus.alloc_ena, 0);
    chk("rst_fwd1", bus.rs1_fwd, 0);
    chk("rst_tag1", bus.rs1_tag, 0);
    chk("rst_cnt", bus.inflight_cnt, 0);
    @(negedge CLK); RST = 0; idle();

    // RAW hazard on x5 (tag 3)
    @(negedge CLK); idle(); disp(5, 0, 0, 1, 3); #1;
    chk("d5_alloc", bus.alloc_ena, 1);
    chk("d5_stall", bus.stall, 0);
    @(negedge CLK); idle(); disp(0, 5, 0, 0, 0);
    bus.wb_valid_mu = 1; bus.wb_index_mu = 3; #1;
    chk("raw_stall", bus.stall, 1);
    chk("raw_alloc", bus.alloc_ena, 0);
    chk("raw_fwd", bus.rs1_fwd, 0);
    chk("raw_cnt", bus.inflight_cnt, 1);
    @(negedge CLK); idle(); disp(0, 5, 5, 0, 0); #1;
    chk("fwd_stall", bus.stall, 0);
    chk("fwd1", bus.rs1_fwd, 1);
    chk("fwd1_tag", bus.rs1_tag, 3);
    chk("fwd2", bus.rs2_fwd, 1);
    chk("fwd2_tag", bus.rs2_tag, 3);
    @(negedge CLK); idle(); commit(5, 3);
    @(negedge CLK); idle(); disp(0, 5, 0, 0, 0); #1;
    chk("cmt_fwd", bus.rs1_fwd, 0);
    chk("cmt_tag", bus.rs1_tag, 0);
    chk("cmt_stall", bus.stall, 0);
    chk("cmt_cnt", bus.inflight_cnt, 0);

    // WAW on x7: tag 2 then tag 4, stale commit of tag 2
    @(negedge CLK); idle(); disp(7, 0, 0, 1, 2);
    @(negedge CLK); idle(); disp(7, 0, 0, 1, 4);
    @(negedge CLK); idle(); commit(7, 2); #1;
    chk("waw_cnt2", bus.inflight_cnt, 2);
    @(negedge CLK); idle(); disp(0, 7, 0, 0, 0); #1;
    chk("waw_busy", bus.stall, 1);
    chk("waw_cnt1", bus.inflight_cnt, 1);
    bus.wb_valid_a = 1; bus.wb_index_a = 4;
    @(negedge CLK); idle(); disp(0, 7, 0, 0, 0); #1;
    chk("waw_fwd", bus.rs1_fwd, 1);
    chk("waw_tag", bus.rs1_tag, 4);

    // x9: same-cycle dispatch (tag 6) and commit of old tag 1
    @(negedge CLK); idle(); disp(9, 0, 0, 1, 1);
    @(negedge CLK); idle(); bus.wb_valid_ls = 1; bus.wb_index_ls = 1;
    @(negedge CLK); idle(); disp(0, 9, 0, 0, 0); #1;
    chk("x9_fwd_old", bus.rs1_fwd, 1);
    chk("x9_tag_old", bus.rs1_tag, 1);
    chk("x9_cnt_pre", bus.inflight_cnt, 2);
    disp(9, 9, 0, 1, 6); commit(9, 1); #1;
    chk("x9_alloc", bus.alloc_ena, 1);
    @(negedge CLK); idle(); disp(0, 9, 7, 0, 0); #1;
    chk("x9_stall", bus.stall, 1);
    chk("x9_fwd", bus.rs1_fwd, 0);
    chk("x9_tag0", bus.rs1_tag, 0);
    chk("x7_fwd", bus.rs2_fwd, 1);
    chk("x7_tag", bus.rs2_tag, 4);
    chk("x9_cnt", bus.inflight_cnt, 2);
    bus.wb_valid_du = 1; bus.wb_index_du = 6;
    @(negedge CLK); idle(); disp(0, 9, 0, 0, 0); #1;
    chk("x9_fwd_new", bus.rs1_fwd, 1);
    chk("x9_tag_new", bus.rs1_tag, 6);

    // Flush with x7, x9, x10..x13 busy
    for (int r = 10; r < 14; r++) begin
      @(negedge CLK); idle(); disp(5'(r), 0, 0, 1, 4'(r - 3));
    end
    @(negedge CLK); idle(); #1;
    chk("fl_cnt6", bus.inflight_cnt, 6);
    disp(14, 0, 0, 1, 11); bus.flush = 1; #1;
    chk("fl_alloc", bus.alloc_ena, 0);
    chk("fl_stall", bus.stall, 0);
    @(negedge CLK); idle(); disp(0, 10, 7, 0, 0); #1;
    chk("fl_stall_after", bus.stall, 0);
    chk("fl_fwd1", bus.rs1_fwd, 0);
    chk("fl_fwd2", bus.rs2_fwd, 0);
    chk("fl_cnt0", bus.inflight_cnt, 0);
    disp(14, 9, 14, 0, 0); #1;
    chk("fl_fwd9", bus.rs1_fwd, 0);
    chk("fl_stall14", bus.stall, 0);

    // x0 never tracked; cb_full blocks dispatch
    @(negedge CLK); idle(); disp(0, 0, 0, 1, 5); #1;
    chk("x0_alloc", bus.alloc_ena, 1);
    @(negedge CLK); idle(); disp(0, 0, 0, 0, 0); #1;
    chk("x0_stall", bus.stall, 0);
    chk("x0_fwd", bus.rs1_fwd, 0);
    chk("x0_cnt", bus.inflight_cnt, 0);
    bus.cb_full = 1; #1;
    chk("full_stall", bus.stall, 1);
    chk("full_alloc", bus.alloc_ena, 0);

    // Counter saturation at 16 and at 0
    repeat (17) begin
      @(negedge CLK); idle(); disp(1, 0, 0, 1, 0);
    end
    @(negedge CLK); idle(); #1;
    chk("sat_hi", bus.inflight_cnt, 16);
    repeat (17) begin
      @(negedge CLK); idle(); commit(1, 0);
    end
    @(negedge CLK); idle(); #1;
    chk("sat_lo", bus.inflight_cnt, 0);

    // Asynchronous reset mid-operation
    @(negedge CLK); idle(); disp(3, 0, 0, 1, 5);
    @(negedge CLK); idle(); disp(0, 3, 0, 0, 0); #1;
    chk("ar_stall_pre", bus.stall, 1);
    chk("ar_cnt_pre", bus.inflight_cnt, 1);
    #1 RST = 1; #1;
    chk("ar_stall", bus.stall, 0);
    chk("ar_cnt", bus.inflight_cnt, 0);
    @(negedge CLK); RST = 0; idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
